// File: rtl/bcd2_down_count.sv
// ---------------------------------------------------------------------------
// bcd2_down_count
//   Two-digit BCD down counter with synchronous parallel load, a preset
//   register, and a one-cycle borrow-out pulse on underflow.
//
//   Parameters
//     RELOAD : 0 -> underflow wraps 00 -> 99
//              1 -> underflow reloads the last loaded preset
//
//   Ports
//     CK   in   1  clock, all state changes on the rising edge
//     AR   in   1  asynchronous active-low reset
//     CE   in   1  count enable (decrement by one)
//     LD   in   1  synchronous load of D (wins over CE)
//     D    in   8  load value, D[7:4] tens, D[3:0] units (digits > 9 clamp to 9)
//     Q    out  8  count, Q[7:4] tens, Q[3:0] units
//     BO   out  1  borrow-out, high for the one cycle after an underflow edge
//     ZERO out  1  combinational, high iff Q == 8'h00
// ---------------------------------------------------------------------------
module bcd2_down_count #(
    parameter bit RELOAD = 1'b0
) (
    input  logic       CK,
    input  logic       AR,
    input  logic       CE,
    input  logic       LD,
    input  logic [7:0] D,
    output logic [7:0] Q,
    output logic       BO,
    output logic       ZERO
);

    localparam int unsigned DigitW = 4;
    localparam int unsigned WordW  = 2 * DigitW;

    localparam logic [DigitW-1:0] DigitZero = DigitW'(0);
    localparam logic [DigitW-1:0] DigitOne  = DigitW'(1);
    localparam logic [DigitW-1:0] DigitNine = DigitW'(9);
    localparam logic [WordW-1:0]  WordZero  = WordW'(8'h00);
    localparam logic [WordW-1:0]  WordNn    = WordW'(8'h99);

    typedef enum logic {
        COUNT = 1'b0,
        UFLOW = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WordW-1:0]   q_q, q_d;
    logic [WordW-1:0]   pre_q, pre_d;
    logic [WordW-1:0]   ld_val;
    logic [DigitW-1:0]  tens, units;
    logic               underflow;

    // Clamp a raw nibble to a legal BCD digit.
    function automatic logic [DigitW-1:0] clamp9(input logic [DigitW-1:0] x);
        return (x > DigitNine) ? DigitNine : x;
    endfunction

    // State, count and preset registers.
    always_ff @(posedge CK or negedge AR) begin
        if (!AR) begin
            state_q <= COUNT;
            q_q     <= WordZero;
            pre_q   <= WordNn;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            pre_q   <= pre_d;
        end
    end

    // Next-state: load > count > hold; the decrement works digit by digit.
    always_comb begin
        q_d       = q_q;
        pre_d     = pre_q;
        state_d   = COUNT;
        underflow = 1'b0;
        tens      = q_q[WordW-1:DigitW];
        units     = q_q[DigitW-1:0];
        ld_val    = {clamp9(D[WordW-1:DigitW]), clamp9(D[DigitW-1:0])};

        if (LD) begin
            q_d   = ld_val;
            pre_d = ld_val;
        end else if (CE) begin
            if (units != DigitZero) begin
                q_d = {tens, units - DigitOne};
            end else if (tens != DigitZero) begin
                q_d = {tens - DigitOne, DigitNine};
            end else begin
                underflow = 1'b1;
                q_d       = RELOAD ? pre_q : WordNn;
            end
        end

        // UFLOW lasts exactly as long as underflow edges keep coming.
        if (underflow) begin
            state_d = UFLOW;
        end
    end

    assign Q    = q_q;
    assign BO   = (state_q == UFLOW);
    assign ZERO = (q_q == WordZero);

endmodule
